// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants (bus widths, register count, enable levels).
package regfile_pkg;
   localparam int         RegAddrBus  = 5;
   localparam int         RegBus      = 32;
   localparam int         RegNum      = 32;
   localparam logic [31:0] ZeroWord   = 32'h0;
   localparam logic [4:0] NOPRegAddr  = 5'd0;
   localparam logic       WriteEnable = 1'b1;
   localparam logic       ReadEnable  = 1'b1;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: writeback, two read ports and load-scoreboard controls of the register file.
interface regfile_if #(parameter int AW = 5, parameter int DW = 32) ();
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re1;
   logic [AW-1:0] raddr1;
   logic [DW-1:0] rdata1;
   logic          busy1;
   logic          re2;
   logic [AW-1:0] raddr2;
   logic [DW-1:0] rdata2;
   logic          busy2;
   logic          set_busy;
   logic [AW-1:0] set_addr;
   logic          flush;
   modport master (output we, waddr, wdata, re1, raddr1, re2, raddr2, set_busy, set_addr, flush,
                   input rdata1, busy1, rdata2, busy2);
   modport slave  (input we, waddr, wdata, re1, raddr1, re2, raddr2, set_busy, set_addr, flush,
                   output rdata1, busy1, rdata2, busy2);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending-load bit per register; a younger load's set beats a
// same-cycle writeback clear, and flush beats both.
module regfile_scoreboard #(
   parameter int REG_NUM = 32,
   parameter int REG_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic              set_busy_i,
   input  logic [REG_AW-1:0] set_addr_i,
   input  logic              flush_i,
   input  logic              re1_i,
   input  logic [REG_AW-1:0] raddr1_i,
   input  logic              byp1_i,
   input  logic              re2_i,
   input  logic [REG_AW-1:0] raddr2_i,
   input  logic              byp2_i,
   output logic              busy1_o,
   output logic              busy2_o
);
   logic [REG_NUM-1:0] busy_q, busy_d;
   always_comb begin
      busy_d = '0;
      for (int i = 1; i < REG_NUM; i++)
         busy_d[i] = flush_i ? 1'b0 :
                     (set_busy_i && set_addr_i == REG_AW'(i)) ? 1'b1 :
                     (wr_i && waddr_i == REG_AW'(i)) ? 1'b0 : busy_q[i];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) busy_q <= '0;
      else busy_q <= busy_d;
   assign busy1_o = re1_i && busy_q[raddr1_i] && !byp1_i;
   assign busy2_o = re2_i && busy_q[raddr2_i] && !byp2_i;
endmodule

// File: rtl/regfile.sv
// regfile: 2-read/1-write register file with x0 hardwired to zero, write-to-read bypass
// and a pending-load scoreboard.
module regfile
   import regfile_pkg::*;
#(
   parameter int REG_NUM = RegNum,
   parameter int REG_AW  = RegAddrBus,
   parameter int REG_DW  = RegBus
) (
   input logic      clk,
   input logic      rst,
   regfile_if.slave bus
);
   logic [REG_DW-1:0] regs_q [1:REG_NUM-1];
   logic [REG_DW-1:0] regs_d [1:REG_NUM-1];
   logic wr, byp1, byp2;
   assign wr   = bus.we == WriteEnable && bus.waddr != '0;
   assign byp1 = wr && bus.re1 == ReadEnable && bus.raddr1 == bus.waddr;
   assign byp2 = wr && bus.re2 == ReadEnable && bus.raddr2 == bus.waddr;
   always_comb begin
      regs_d = regs_q;
      if (wr) regs_d[bus.waddr] = bus.wdata;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) for (int i = 1; i < REG_NUM; i++) regs_q[i] <= '0;
      else regs_q <= regs_d;
   // rst gates the bypass path too, so outputs are quiet throughout reset
   assign bus.rdata1 = (!rst || !bus.re1 || bus.raddr1 == '0) ? '0 :
                       byp1 ? bus.wdata : regs_q[bus.raddr1];
   assign bus.rdata2 = (!rst || !bus.re2 || bus.raddr2 == '0) ? '0 :
                       byp2 ? bus.wdata : regs_q[bus.raddr2];
   regfile_scoreboard #(.REG_NUM(REG_NUM), .REG_AW(REG_AW)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr),
      .waddr_i   (bus.waddr),
      .set_busy_i(bus.set_busy),
      .set_addr_i(bus.set_addr),
      .flush_i   (bus.flush),
      .re1_i     (bus.re1),
      .raddr1_i  (bus.raddr1),
      .byp1_i    (byp1),
      .re2_i     (bus.re2),
      .raddr2_i  (bus.raddr2),
      .byp2_i    (byp2),
      .busy1_o   (bus.busy1),
      .busy2_o   (bus.busy2)
   );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenario tasks with inline checks for the register file.
module tb_regfile;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   regfile_if #(.AW(5), .DW(32)) bus ();
   regfile dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic idle();
      bus.we = 0; bus.waddr = 0; bus.wdata = 0;
      bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
      bus.set_busy = 0; bus.set_addr = 0; bus.flush = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      bus.we = 1; bus.waddr = 5; bus.wdata = 32'hCAFEF00D;
      bus.re1 = 1; bus.raddr1 = 5; bus.re2 = 1; bus.raddr2 = 6;
      @(negedge clk); #1;
      checks++;
      if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h want 0", bus.rdata1); end
      checks++;
      if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0 || bus.rdata2 !== 32'h0) begin
         errors++; $display("FAIL reset_outs got %b/%b/%h want 0/0/0", bus.busy1, bus.busy2, bus.rdata2);
      end
      idle();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_write_read();
      bus.we = 1; bus.waddr = 5; bus.wdata = 32'h12345678;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 5; #1;
      checks++;
      if (bus.rdata1 !== 32'h12345678) begin errors++; $display("FAIL wr_rd_x5 got %h want 12345678", bus.rdata1); end
      checks++;
      if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL wr_rd_busy got %b want 0", bus.busy1); end
      bus.re1 = 0; #1;
      checks++;
      if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL re1_off got %h want 0", bus.rdata1); end
      bus.re1 = 1; bus.re2 = 1; bus.raddr2 = 5; #1;
      checks++;
      if (bus.rdata1 !== 32'h12345678 || bus.rdata2 !== 32'h12345678) begin
         errors++; $display("FAIL same_reg_both got %h/%h want 12345678", bus.rdata1, bus.rdata2);
      end
      idle();
   endtask

   task automatic test_x0();
      bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFFFFFF;
      bus.re1 = 1; bus.raddr1 = 0; #1;
      checks++;
      if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL x0_nobypass got %h want 0", bus.rdata1); end
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 0; bus.re2 = 1; bus.raddr2 = 0; #1;
      checks++;
      if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
         errors++; $display("FAIL x0_read got %h/%h want 0/0", bus.rdata1, bus.rdata2);
      end
      idle();
   endtask

   task automatic test_bypass();
      bus.we = 1; bus.waddr = 7; bus.wdata = 32'hA5A5A5A5;
      bus.re2 = 1; bus.raddr2 = 7; bus.re1 = 1; bus.raddr1 = 5; #1;
      checks++;
      if (bus.rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_x7 got %h want a5a5a5a5", bus.rdata2); end
      checks++;
      if (bus.rdata1 !== 32'h12345678) begin errors++; $display("FAIL bypass_other got %h want 12345678", bus.rdata1); end
      bus.re2 = 0; #1;
      checks++;
      if (bus.rdata2 !== 32'h0) begin errors++; $display("FAIL bypass_re_off got %h want 0", bus.rdata2); end
      cyc();
      idle(); bus.re2 = 1; bus.raddr2 = 7; #1;
      checks++;
      if (bus.rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL stored_x7 got %h want a5a5a5a5", bus.rdata2); end
      idle();
   endtask

   task automatic test_busy();
      bus.set_busy = 1; bus.set_addr = 9;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 9; bus.raddr2 = 9; #1;
      checks++;
      if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL busy_x9 got %b want 1", bus.busy1); end
      checks++;
      if (bus.busy2 !== 1'b0) begin errors++; $display("FAIL busy_re2_off got %b want 0", bus.busy2); end
      bus.we = 1; bus.waddr = 9; bus.wdata = 32'hDEADBEEF; #1;
      checks++;
      if (bus.busy1 !== 1'b0 || bus.rdata1 !== 32'hDEADBEEF) begin
         errors++; $display("FAIL busy_bypass got %b/%h want 0/deadbeef", bus.busy1, bus.rdata1);
      end
      cyc();
      bus.we = 0; #1;
      checks++;
      if (bus.busy1 !== 1'b0 || bus.rdata1 !== 32'hDEADBEEF) begin
         errors++; $display("FAIL busy_cleared got %b/%h want 0/deadbeef", bus.busy1, bus.rdata1);
      end
      idle();
   endtask

   task automatic test_set_clear_flush();
      bus.set_busy = 1; bus.set_addr = 3; bus.we = 1; bus.waddr = 3; bus.wdata = 32'h33;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 3; #1;
      checks++;
      if (bus.busy1 !== 1'b1 || bus.rdata1 !== 32'h33) begin
         errors++; $display("FAIL set_wins_x3 got %b/%h want 1/33", bus.busy1, bus.rdata1);
      end
      bus.flush = 1; bus.set_busy = 1; bus.set_addr = 4; bus.we = 1; bus.waddr = 4; bus.wdata = 32'h44;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 4; bus.re2 = 1; bus.raddr2 = 3; #1;
      checks++;
      if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL flush_over_set got %b want 0", bus.busy1); end
      checks++;
      if (bus.busy2 !== 1'b0) begin errors++; $display("FAIL flush_clears_x3 got %b want 0", bus.busy2); end
      checks++;
      if (bus.rdata1 !== 32'h44) begin errors++; $display("FAIL flush_write got %h want 44", bus.rdata1); end
      idle();
   endtask

   task automatic test_async_reset();
      for (int i = 1; i < 32; i++) begin
         bus.we = 1; bus.waddr = 5'(i); bus.wdata = 32'h01010101 * i;
         cyc();
      end
      idle(); bus.set_busy = 1; bus.set_addr = 2;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 31; bus.re2 = 1; bus.raddr2 = 2; #1;
      checks++;
      if (bus.rdata1 !== 32'h1F1F1F1F || bus.busy2 !== 1'b1) begin
         errors++; $display("FAIL pre_reset got %h/%b want 1f1f1f1f/1", bus.rdata1, bus.busy2);
      end
      #2 rst = 0;
      #1;
      checks++;
      if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0 || bus.busy2 !== 1'b0) begin
         errors++; $display("FAIL async_reset got %h/%h/%b want 0/0/0", bus.rdata1, bus.rdata2, bus.busy2);
      end
      @(negedge clk);
      rst = 1;
      for (int i = 1; i < 32; i++) begin
         bus.raddr1 = 5'(i); bus.raddr2 = 5'(32 - i); #1;
         checks++;
         if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++; $display("FAIL post_reset_x%0d got %h/%h want 0/0", i, bus.rdata1, bus.rdata2);
         end
      end
      idle(); bus.we = 1; bus.waddr = 12; bus.wdata = 32'h0BADF00D;
      cyc();
      idle(); bus.re1 = 1; bus.raddr1 = 12; #1;
      checks++;
      if (bus.rdata1 !== 32'h0BADF00D) begin errors++; $display("FAIL first_write got %h want 0badf00d", bus.rdata1); end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_busy();
      test_set_clear_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL: parameter REG_NUM, default 32, number of architectural registers.
REQ-002 SHALL: parameter REG_AW, default 5, register address width.
REQ-003 SHALL: parameter REG_DW, default 32, register data width.
REQ-004 SHALL: port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 SHALL: port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL: port we  in  1  writeback enable, driven by the WB stage write-enable.
REQ-007 SHALL: port waddr  in  REG_AW  writeback destination register.
REQ-008 SHALL: port wdata  in  REG_DW  writeback data.
REQ-009 SHALL: port re1  in  1  read-port-1 enable from ID.
REQ-010 SHALL: port raddr1  in  REG_AW  read-port-1 address.
REQ-011 SHALL: port rdata1  out  REG_DW  read-port-1 data.
REQ-012 SHALL: port busy1  out  1  read-port-1 operand has a pending load write.
REQ-013 SHALL: ports re2, raddr2, rdata2, busy2 define read port 2, identical to read port 1.
REQ-014 SHALL: port set_busy  in  1  a load targeting set_addr issued this cycle.
REQ-015 SHALL: port set_addr  in  REG_AW  destination of the issued load.
REQ-016 SHALL: port flush  in  1  pipeline flush; discard all pending-load marks.

Function
REQ-017 SHALL: storage is REG_NUM x REG_DW; x0 is not stored and always reads 0.
REQ-018 SHALL: write occurs at posedge clk when we=1 and waddr!=0; writes to x0 are dropped.
REQ-019 SHALL: reads are combinational (zero latency); rdataN=0 when reN=0 or raddrN=0.
REQ-020 SHALL: write-to-read bypass: when we=1, waddr!=0, reN=1 and raddrN==waddr, rdataN=wdata in that same cycle.
REQ-021 SHALL: otherwise rdataN = stored value of raddrN.
REQ-022 SHALL: scoreboard holds one busy bit per register; bit 0 is always 0.
REQ-023 SHALL: at posedge clk, set_busy=1 with set_addr!=0 sets busy[set_addr].
REQ-024 SHALL: at posedge clk, we=1 with waddr!=0 clears busy[waddr].
REQ-025 SHALL: simultaneous set and clear of the same address: set wins, because the issued load is younger.
REQ-026 SHALL: flush=1 clears all busy bits at posedge clk and overrides a same-cycle set_busy.
REQ-027 SHALL: a write on a flush cycle still updates storage.
REQ-028 SHALL: busyN = reN & busy[raddrN], forced to 0 when the REQ-020 bypass applies to port N.
REQ-029 SHALL: both read ports are independent and may name the same register.

Reset
REQ-030 SHALL: while rst=0, asynchronously clear all registers and all busy bits.
REQ-031 SHALL: while rst=0, drive rdata1, rdata2, busy1 and busy2 to 0, ignoring all inputs.
REQ-032 SHALL: on rst release, the first write takes effect at the first posedge clk with rst=1.

Structure
REQ-033 SHALL: the shared defines header holds the RegAddrBus, RegBus, RegNum, ZeroWord, NOPRegAddr, WriteEnable and ReadEnable constants.
REQ-034 SHALL: one sub-module, regfile_scoreboard, holds the busy vector and implements REQ-022 to REQ-028; the storage array and read muxes stay in regfile.

Verification
REQ-035 SHALL: reset, then write x5=0x12345678, then read raddr1=5, re1=1 -> rdata1=0x12345678, busy1=0.
REQ-036 SHALL: we=1, waddr=0, wdata=0xFFFFFFFF, then read x0 on both ports -> rdata1=rdata2=0.
REQ-037 SHALL: same-cycle we=1, waddr=7, wdata=0xA5A5A5A5 with re2=1, raddr2=7 -> rdata2=0xA5A5A5A5 that cycle.
REQ-038 SHALL: set_busy on x9, then read x9 -> busy1=1; a write to x9 shows busy1=0 and bypassed data in that cycle, and x9 stays clear afterward.
REQ-039 SHALL: simultaneous set_busy and write on x3 -> busy[3]=1 next cycle; simultaneous flush and set_busy on x4 -> busy[4]=0.
REQ-040 SHALL: assert rst=0 asynchronously mid-cycle after writes to x1..x31 -> outputs 0 at once, and all registers read 0 after release.
